// File: rtl/pipe_reg_if.sv
`default_nettype none
// ============================================================================
// pipe_reg_if : valid/ready handshake bundle for the pipe_reg pipeline
// Revision    : 1.0
// ============================================================================
interface pipe_reg_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3
);
  logic                         in_valid_i;
  logic                         in_ready_o;
  logic [WIDTH-1:0]             in_data_i;
  logic                         out_valid_o;
  logic                         out_ready_i;
  logic [WIDTH-1:0]             out_data_o;
  logic [$clog2(DEPTH+1)-1:0]   count_o;

  // The pipeline itself is the slave; the environment feeding and draining it is the master.
  modport slave (
    input  in_valid_i, in_data_i, out_ready_i,
    output in_ready_o, out_valid_o, out_data_o, count_o
  );

  modport master (
    output in_valid_i, in_data_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_data_o, count_o
  );
endinterface
`default_nettype wire

// File: rtl/pipe_reg.sv
`default_nettype none
// ============================================================================
// pipe_reg : DEPTH-stage valid/ready register pipeline with bubble collapse
// Revision : 1.0
// ============================================================================
module pipe_reg #(
  parameter int               WIDTH      = 8,
  parameter int               DEPTH      = 3,
  parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
  input  wire logic clk,
  input  wire logic reset_n,
  input  wire logic flush_i,
  pipe_reg_if.slave bus
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] r_valid;
  logic [WIDTH-1:0] r_data [DEPTH];
  logic [DEPTH-1:0] w_ready;
  logic [CW-1:0]    w_count;

  // A stage can load unless it and every stage after it are full while the output is blocked.
  generate
    for (genvar k = 0; k < DEPTH; k++) begin : g_ready
      assign w_ready[k] = bus.out_ready_i | ~(&r_valid[DEPTH-1:k]);
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        r_data[k] <= RESET_DATA;
      end
    end else if (flush_i) begin
      r_valid <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        r_data[k] <= RESET_DATA;
      end
    end else begin
      if (w_ready[0]) begin
        r_valid[0] <= bus.in_valid_i;
        r_data[0]  <= bus.in_data_i;
      end
      for (int k = 1; k < DEPTH; k++) begin
        if (w_ready[k]) begin
          r_valid[k] <= r_valid[k-1];
          r_data[k]  <= r_data[k-1];
        end
      end
    end
  end

  always_comb begin
    w_count = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_count = w_count + CW'(r_valid[k]);
    end
  end

  assign bus.in_ready_o  = w_ready[0] & ~flush_i;
  assign bus.out_valid_o = r_valid[DEPTH-1] & ~flush_i;
  assign bus.out_data_o  = r_data[DEPTH-1];
  assign bus.count_o     = w_count;

endmodule
`default_nettype wire

// File: doc/pipe_reg.md
PIPE_REG -- requirements
Module: pipe_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 3, number of register stages (>=1).
REQ-003 SHALL have parameter RESET_DATA, default 0, WIDTH-bit value loaded into every data stage on reset and flush.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port flush_i  input  1  synchronous clear of all stages.
REQ-007 SHALL have port in_valid_i  input  1  upstream data valid.
REQ-008 SHALL have port in_ready_o  output  1  pipeline accepts data this cycle.
REQ-009 SHALL have port in_data_i  input  WIDTH  upstream data.
REQ-010 SHALL have port out_valid_o  output  1  last stage holds valid data.
REQ-011 SHALL have port out_ready_i  input  1  downstream accepts data.
REQ-012 SHALL have port out_data_o  output  WIDTH  last-stage data.
REQ-013 SHALL have port count_o  output  $clog2(DEPTH+1)  number of valid stages.

Function
REQ-014 SHALL hold, per stage k (0 = input, DEPTH-1 = output), one valid flag and one WIDTH-bit data register.
REQ-015 SHALL compute ready combinationally: ready[DEPTH-1] = out_ready_i | ~valid[DEPTH-1]; ready[k] = ready[k+1] | ~valid[k]; in_ready_o = ready[0] & ~flush_i.
REQ-016 SHALL transfer into stage k when ready[k] is high: stage 0 loads in_data_i/in_valid_i; stage k>0 loads stage k-1 data/valid.
REQ-017 SHALL hold data and valid of any stage whose ready is low (no overwrite, no loss).
REQ-018 SHALL collapse bubbles: an empty stage accepts from its predecessor even when downstream is stalled.
REQ-019 SHALL have latency DEPTH cycles from an input transfer to out_valid_o when no stall occurs; throughput one transfer per cycle.
REQ-020 SHALL keep out_data_o stable while out_valid_o=1 and out_ready_i=0.
REQ-021 SHALL drive out_valid_o = valid[DEPTH-1] & ~flush_i and out_data_o = data[DEPTH-1].
REQ-022 SHALL, when flush_i=1 at a clock edge, clear all valid flags, load RESET_DATA into all data stages, and accept no input; flush has priority over all transfers.
REQ-023 SHALL, when full with out_ready_i=1 and in_valid_i=1 in the same cycle, perform both transfers; count_o unchanged.
REQ-024 SHALL keep count_o equal to the population of valid flags after every edge, range 0..DEPTH, never wrapping.
REQ-025 SHALL preserve strict FIFO order; no duplication or reordering.

Reset
REQ-026 SHALL, when reset_n=0, immediately (asynchronously) clear all valid flags, load RESET_DATA into all data stages, and drive count_o=0, out_valid_o=0, out_data_o=RESET_DATA.
REQ-027 SHALL, when reset_n=0, drive in_ready_o=1 (all stages empty) and, on reset_n rising, accept data on the first clock edge.
REQ-028 SHALL have reset asserted mid-operation discard all in-flight data with no output transfer.

Verification (WIDTH=8, DEPTH=3, RESET_DATA=0)
REQ-029 SHALL cover stream: out_ready_i=1, push 0x11,0x22,0x33 on consecutive edges -> out_valid_o high with 0x11,0x22,0x33 on the 3rd,4th,5th edges after the first push; count_o peaks at 3.
REQ-030 SHALL cover stall: out_ready_i=0, push 0xA1..0xA4 -> first three accepted, count_o=3, in_ready_o=0, 0xA4 held upstream; raise out_ready_i -> 0xA1,0xA2,0xA3,0xA4 in order.
REQ-031 SHALL cover bubble collapse: out_ready_i=0, push 0x05 then wait 5 cycles, push 0x06 -> 0x06 reaches stage 1 while 0x05 is stuck in stage 2; count_o=2.
REQ-032 SHALL cover full-with-simultaneous-pop: full with 0x01,0x02,0x03, out_ready_i=1, in_valid_i=1 data 0x04 -> 0x01 leaves, 0x04 enters, count_o stays 3.
REQ-033 SHALL cover flush: count_o=2, flush_i=1 with in_valid_i=1 -> in_ready_o=0 and out_valid_o=0 that cycle; next edge count_o=0, out_data_o=0x00, input not captured.
REQ-034 SHALL cover async reset: drop reset_n between edges while count_o=3 -> count_o=0, out_valid_o=0, out_data_o=0x00 before the next edge.
